// File: rtl/button_conditioner_pkg.sv
// Shared board-I/O definitions: per-button debounce state encoding and the
// default timing constants for a 100 MHz board clock.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_REL    = 2'd0,
        ST_PEND_P = 2'd1,
        ST_PRS    = 2'd2,
        ST_PEND_R = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_N_BTN           = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;    // 20 ms
    localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;  // 1 s
    localparam int unsigned DEF_CNT_W           = 27;

endpackage : button_conditioner_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, debounce FSM, and the long-press timer.
// Every output is a flop, so nothing from raw_i reaches the outputs combinationally.
module btn_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $fatal(1, "btn_debounce_ch: DEBOUNCE_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        (64'd1 << CNT_W) <= 64'(LONG_CYCLES)) begin : g_bad_cnt_w
        $fatal(1, "btn_debounce_ch: CNT_W too narrow for the timing constants");
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             long_q, long_d;
    logic             deb_done, long_sat, long_hit;

    // cnt_q is 0 in REL and PRS, so DEBOUNCE_CYCLES=1 completes on the first observation.
    assign deb_done = (cnt_q == DEB_LAST);
    assign long_sat = (long_cnt_q == LONG_MAX);
    assign long_hit = (LONG_CYCLES != 0) && (long_cnt_q == LONG_MAX - CNT_ONE);

    // NOTE: every _d gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        long_cnt_d = long_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        long_d     = 1'b0;

        unique case (state_q)
            ST_REL, ST_PEND_P: begin
                if (!sync2_q) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                end else if (deb_done) begin
                    state_d    = ST_PRS;
                    cnt_d      = '0;
                    long_cnt_d = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                end else begin
                    state_d = ST_PEND_P;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_PRS, ST_PEND_R: begin
                long_d = long_hit;
                if (!long_sat) begin
                    long_cnt_d = long_cnt_q + CNT_ONE;
                end
                if (sync2_q) begin
                    state_d = ST_PRS;
                    cnt_d   = '0;
                end else if (deb_done) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    state_d = ST_PEND_R;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // NOTE: reset is synchronous -- it only takes effect on a clock edge, so it sits inside the edge branch.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_REL;
            cnt_q      <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            long_cnt_q <= long_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            long_q     <= long_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign long_o  = long_q;

endmodule : btn_debounce_ch

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent debounce channels producing clean
// levels plus press, release and long-press pulses for the CPU top level.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i  (fpga_clk),
            .rst_i  (fpga_rst),
            .raw_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .rise_o (btn_rise[i]),
            .fall_o (btn_fall[i]),
            .long_o (btn_long[i])
        );
    end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// k counts edges since a scenario's first drive; outputs are sampled 1 time unit after each edge.
module tb_button_conditioner;

    localparam int unsigned N  = 5;
    localparam int unsigned D  = 4;
    localparam int unsigned L  = 16;
    localparam int unsigned CW = 27;

    localparam logic [4:0] M0  = 5'b00001;
    localparam logic [4:0] M1  = 5'b00010;
    localparam logic [4:0] M2  = 5'b00100;
    localparam logic [4:0] M3  = 5'b01000;
    localparam logic [4:0] M4  = 5'b10000;
    localparam logic [4:0] ALL = 5'b11111;

    logic         fpga_clk = 1'b0;
    logic         fpga_rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (CW)
    ) dut (
        .fpga_clk (fpga_clk),
        .fpga_rst (fpga_rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic step();
        @(posedge fpga_clk);
        #1;
        k++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] lvl, input logic [4:0] rise,
                              input logic [4:0] fall, input logic [4:0] lng);
        check($sformatf("%s k=%0d level", tag, k), 32'(btn_level), 32'(lvl));
        check($sformatf("%s k=%0d rise", tag, k), 32'(btn_rise), 32'(rise));
        check($sformatf("%s k=%0d fall", tag, k), 32'(btn_fall), 32'(fall));
        check($sformatf("%s k=%0d long", tag, k), 32'(btn_long), 32'(lng));
    endtask

    function automatic logic [4:0] at(input bit cond, input logic [4:0] mask);
        return cond ? mask : 5'b0;
    endfunction

    task automatic idle(input int n);
        btn_raw = '0;
        repeat (n) step();
        k = 0;
    endtask

    bit bounce_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset with every button pressed: nothing may leak through.
        fpga_rst = 1'b1;
        btn_raw  = ALL;
        repeat (3) begin
            step();
            check_outs("reset", 5'b0, 5'b0, 5'b0, 5'b0);
        end
        fpga_rst = 1'b0;
        idle(6);

        // Clean press and release of button 4: rise after k=6, fall after k=14.
        btn_raw = M4;
        repeat (8) begin
            step();
            check_outs("clean", at(k >= 6, M4), at(k == 6, M4), 5'b0, 5'b0);
        end
        btn_raw = '0;
        repeat (8) begin
            step();
            check_outs("clean_rel", at(k < 14, M4), 5'b0, at(k == 14, M4), 5'b0);
        end
        idle(6);

        // Bounce on button 3, including a 3-cycle burst one short of the threshold.
        for (int i = 0; i < 18; i++) begin
            btn_raw = ((i < 8) ? bounce_pat[i] : 1'b1) ? M3 : 5'b0;
            step();
            check_outs("bounce", at(k >= 14, M3), at(k == 14, M3), 5'b0, 5'b0);
        end
        btn_raw = '0;
        repeat (8) begin
            step();
            check_outs("bounce_rel", at(k < 24, M3), 5'b0, at(k == 24, M3), 5'b0);
        end
        idle(6);

        // Long press on button 0: one long pulse 16 cycles after rise, no re-fire.
        btn_raw = M0;
        repeat (46) begin
            step();
            check_outs("long", at(k >= 6, M0), at(k == 6, M0), 5'b0, at(k == 22, M0));
        end
        btn_raw = '0;
        repeat (8) begin
            step();
            check_outs("long_rel", at(k < 52, M0), 5'b0, at(k == 52, M0), 5'b0);
        end
        idle(6);

        // Release of button 1 with a 2-cycle glitch back to 1 mid-PEND_R.
        for (int i = 0; i < 22; i++) begin
            btn_raw = ((i < 8) || (i == 10) || (i == 11)) ? M1 : 5'b0;
            step();
            check_outs("glitch", at(k >= 6 && k < 18, M1), at(k == 6, M1),
                       at(k == 18, M1), 5'b0);
        end
        idle(6);

        // Release completing on the same edge the long timer expires.
        for (int i = 0; i < 24; i++) begin
            btn_raw = (i < 16) ? M2 : 5'b0;
            step();
            check_outs("long_fall", at(k >= 6 && k < 22, M2), at(k == 6, M2),
                       at(k == 22, M2), at(k == 22, M2));
        end
        idle(6);

        // Reset pulse while button 2 is held in PRS; fresh press detected afterwards.
        btn_raw = M2;
        repeat (10) begin
            step();
            check_outs("rst_pre", at(k >= 6, M2), at(k == 6, M2), 5'b0, 5'b0);
        end
        fpga_rst = 1'b1;
        step();
        check_outs("rst_hit", 5'b0, 5'b0, 5'b0, 5'b0);
        fpga_rst = 1'b0;
        repeat (8) begin
            step();
            check_outs("rst_post", at(k >= 17, M2), at(k == 17, M2), 5'b0, 5'b0);
        end
        btn_raw = '0;
        repeat (8) begin
            step();
            check_outs("rst_rel", at(k < 25, M2), 5'b0, at(k == 25, M2), 5'b0);
        end
        idle(6);

        // All five buttons pressed and released together.
        btn_raw = ALL;
        repeat (8) begin
            step();
            check_outs("all", at(k >= 6, ALL), at(k == 6, ALL), 5'b0, 5'b0);
        end
        btn_raw = '0;
        repeat (8) begin
            step();
            check_outs("all_rel", at(k < 14, ALL), 5'b0, at(k == 14, ALL), 5'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_button_conditioner
